// File: rtl/ldpc_enc_pkg.sv
// ldpc_enc_pkg
//  Shared types and default geometry for the QC LDPC encoder frame scheduler.
//  sched_state_t : scheduler FSM states
//  LDPC_Z / LDPC_INFO_LEN / LDPC_WORD_LEN : default code geometry
//  K_BLK         : Z-bit words per info block for the default geometry
//  blk_exact()   : true when the info length splits into whole Z-bit words
package ldpc_enc_pkg;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HOLD} sched_state_t;

  localparam int LDPC_Z        = 27;
  localparam int LDPC_INFO_LEN = 486;
  localparam int LDPC_WORD_LEN = 648;
  localparam int K_BLK         = LDPC_INFO_LEN / LDPC_Z;

  function automatic bit blk_exact(input int info_len, input int z);
    return (info_len % z) == 0;
  endfunction

endpackage

// File: rtl/ldpc_valid_dly.sv
// ldpc_valid_dly
//  DEPTH-deep shift line for a single strobe, used to align the ROM issue
//  strobe with the data coming back from a DEPTH-cycle synchronous ROM.
//  clk : clock
//  clr : synchronous clear of the whole line
//  d   : strobe in
//  q   : strobe out, DEPTH cycles later
module ldpc_valid_dly #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] vld_pipe;

  always_ff @(posedge clk) begin
    if (clr) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[0] <= d;
      for (int i = 1; i < DEPTH; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  assign q = vld_pipe[DEPTH-1];

endmodule

// File: rtl/ldpc_enc_frame_sched.sv
// ldpc_enc_frame_sched
//  Frame scheduler for the QC LDPC encoder. Reads one info block as K_BLK
//  consecutive Z-bit ROM words, streams them to the encoder as valid/data
//  beats, waits out the encoder latency, captures the codeword and offers it
//  on a valid/ready port.
//  Optional build macro LDPC_SCHED_FRAME_CNT_EN adds frame_cnt[15:0], a
//  wrapping count of transferred codewords.
//  Ports:
//   clk, rst      : clock, synchronous active-high reset
//   start         : begin a frame (taken in IDLE, or in HOLD on the handshake cycle)
//   busy          : high in every state but IDLE
//   rom_addr      : ROM read address
//   rom_data      : ROM read data, ROM_LAT cycles after rom_addr
//   enc_valid     : encoder beat strobe
//   enc_data      : encoder beat word (registered rom_data)
//   enc_codeword  : encoder result
//   cw_valid      : captured codeword available
//   cw_ready      : downstream accepts codeword
//   codeword      : captured codeword, stable while cw_valid
module ldpc_enc_frame_sched
  import ldpc_enc_pkg::*;
#(
  parameter int Z                = LDPC_Z,
  parameter int LDPC_INFO_LENGTH = LDPC_INFO_LEN,
  parameter int LDPC_WORD_LENGTH = LDPC_WORD_LEN,
  parameter int ADDR_W           = 5,
  parameter int BASE_ADDR        = 0,
  parameter int ROM_LAT          = 1,
  parameter int ENC_LAT          = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  output logic                        busy,
  output logic [ADDR_W-1:0]           rom_addr,
  input  logic [Z-1:0]                rom_data,
  output logic                        enc_valid,
  output logic [Z-1:0]                enc_data,
  input  logic [LDPC_WORD_LENGTH-1:0] enc_codeword,
  output logic                        cw_valid,
  input  logic                        cw_ready,
  output logic [LDPC_WORD_LENGTH-1:0] codeword
`ifdef LDPC_SCHED_FRAME_CNT_EN
  ,
  output logic [15:0]                 frame_cnt
`endif
);

  localparam int BLK_CNT   = LDPC_INFO_LENGTH / Z;
  localparam int BEAT_W    = $clog2(BLK_CNT + 1);
  localparam int DRN_W     = $clog2(ROM_LAT + ENC_LAT + 2);
  // From the cycle after the last issue: ROM_LAT + 1 cycles until the last
  // beat is on enc_valid, then ENC_LAT more until the encoder output settles.
  localparam int DRAIN_CYC = ROM_LAT + ENC_LAT + 1;

  if (!blk_exact(LDPC_INFO_LENGTH, Z)) begin : g_bad_len
    $error("LDPC_INFO_LENGTH must be a multiple of Z");
  end

  sched_state_t      state, state_nx;
  logic [BEAT_W-1:0] beat;
  logic [DRN_W-1:0]  drn;
  logic              last_beat, drain_done, issue, issue_dly, hshk;

  assign last_beat  = beat == BEAT_W'(BLK_CNT - 1);
  assign drain_done = drn == DRN_W'(DRAIN_CYC - 1);
  assign issue      = state == FETCH;
  assign hshk       = cw_valid && cw_ready;

  assign busy     = state != IDLE;
  assign cw_valid = state == HOLD;
  assign rom_addr = issue ? ADDR_W'(BASE_ADDR) + ADDR_W'(beat) : ADDR_W'(BASE_ADDR);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = FETCH;
      FETCH:   if (last_beat) state_nx = DRAIN;
      DRAIN:   if (drain_done) state_nx = HOLD;
      HOLD:    if (cw_ready) state_nx = start ? FETCH : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Issue strobe follows the ROM read latency; one more register stage below
  // lines enc_valid up with the registered rom_data.
  ldpc_valid_dly #(.DEPTH(ROM_LAT)) u_vld_dly (
    .clk (clk),
    .clr (rst),
    .d   (issue),
    .q   (issue_dly)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      beat      <= '0;
      drn       <= '0;
      enc_valid <= 1'b0;
      enc_data  <= '0;
      codeword  <= '0;
    end else begin
      state     <= state_nx;
      // Counters idle at zero outside their state, so entering always starts clean.
      beat      <= (state == FETCH) ? beat + BEAT_W'(1) : '0;
      drn       <= (state == DRAIN) ? drn + DRN_W'(1) : '0;
      enc_valid <= issue_dly;
      if (issue_dly) enc_data <= rom_data;
      if (state == DRAIN && drain_done) codeword <= enc_codeword;
    end
  end

`ifdef LDPC_SCHED_FRAME_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)       frame_cnt <= '0;
    else if (hshk) frame_cnt <= frame_cnt + 16'd1;
  end
`else
  logic unused_hshk;
  assign unused_hshk = hshk;
`endif

endmodule
